// File: rtl/ram_mrmw.sv
// Multi-port RAM: NUM_WR write ports and NUM_RD registered read ports on one array.
// Lowest-index writer wins a shared address; a written bitmap masks stale contents.
module ram_mrmw #(
  parameter int DATA_SIZE      = 16,
  parameter int RAM_DEPTH_LOG2 = 5,
  parameter int NUM_WR         = 2,
  parameter int NUM_RD         = 2,
  parameter int BYPASS         = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic [NUM_WR-1:0]                data_wren,
  input  logic [NUM_WR*RAM_DEPTH_LOG2-1:0] addr_wr,
  input  logic [NUM_WR*DATA_SIZE-1:0]      data_in,
  input  logic [NUM_RD-1:0]                data_rden,
  input  logic [NUM_RD*RAM_DEPTH_LOG2-1:0] addr_rd,
  output logic [NUM_RD*DATA_SIZE-1:0]      data_out,
  output logic [NUM_RD-1:0]                data_valid,
  output logic [RAM_DEPTH_LOG2:0]          fill_count,
  output logic                             RAM_full,
  output logic                             wr_collision
);

  localparam int AW        = RAM_DEPTH_LOG2;
  localparam int DW        = DATA_SIZE;
  localparam int RAM_DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(RAM_DEPTH);

  logic [DW-1:0]        mem [RAM_DEPTH];
  logic [RAM_DEPTH-1:0] written_q, written_d;
  logic [AW:0]          fill_q, fill_d;
  logic                 full_q, full_d;
  logic                 coll_q, coll_d;
  logic [NUM_RD*DW-1:0] dout_q, dout_d;
  logic [NUM_RD-1:0]    valid_q, valid_d;

  logic [NUM_WR-1:0]    win;
  logic [RAM_DEPTH-1:0] ent_we;
  logic [DW-1:0]        ent_wd [RAM_DEPTH];
  logic [AW:0]          new_cnt;

  // A port wins only if no lower-index enabled port targets the same address.
  always_comb begin
    win    = '0;
    coll_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      win[i] = data_wren[i] & ~clear;
      for (int k = 0; k < i; k++) begin
        if (data_wren[k] && data_wren[i] &&
            addr_wr[k*AW +: AW] == addr_wr[i*AW +: AW]) begin
          win[i] = 1'b0;
          coll_d = 1'b1;
        end
      end
    end
    coll_d = coll_d & ~clear;
  end

  always_comb begin
    ent_we = '0;
    for (int e = 0; e < RAM_DEPTH; e++) begin
      ent_wd[e] = '0;
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (win[i]) begin
        ent_we[addr_wr[i*AW +: AW]] = 1'b1;
        ent_wd[addr_wr[i*AW +: AW]] = data_in[i*DW +: DW];
      end
    end
  end

  always_comb begin
    new_cnt = '0;
    for (int e = 0; e < RAM_DEPTH; e++) begin
      new_cnt = new_cnt + (AW+1)'(ent_we[e] & ~written_q[e]);
    end
    if (clear) begin
      written_d = '0;
      fill_d    = '0;
    end else begin
      written_d = written_q | ent_we;
      fill_d    = fill_q + new_cnt;
    end
    full_d = (fill_d == DEPTH_CNT);
  end

  // Reads see pre-edge state; ent_we is already suppressed by clear.
  always_comb begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rdata;
    ra      = '0;
    rdata   = '0;
    dout_d  = dout_q;
    valid_d = data_rden;
    for (int j = 0; j < NUM_RD; j++) begin
      ra    = addr_rd[j*AW +: AW];
      rdata = written_q[ra] ? mem[ra] : '0;
      if (BYPASS != 0 && ent_we[ra]) begin
        rdata = ent_wd[ra];
      end
      if (data_rden[j]) begin
        dout_d[j*DW +: DW] = rdata;
      end
    end
  end

  for (genvar gi = 0; gi < RAM_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (ent_we[gi]) begin
        mem[gi] <= ent_wd[gi];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      written_q <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      coll_q    <= 1'b0;
      dout_q    <= '0;
      valid_q   <= '0;
    end else begin
      written_q <= written_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      coll_q    <= coll_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
    end
  end

  assign data_out     = dout_q;
  assign data_valid   = valid_q;
  assign fill_count   = fill_q;
  assign RAM_full     = full_q;
  assign wr_collision = coll_q;

endmodule

// File: tb/tb_ram_mrmw.sv
// Bench for ram_mrmw: directed scenarios plus randomized traffic against an array/bitmap model.
module tb_ram_mrmw;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int NW    = 2;
  localparam int NR    = 2;
  localparam int BYP   = 1;
  localparam int DEPTH = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic [NW-1:0]     data_wren = '0;
  logic [NW*AW-1:0]  addr_wr = '0;
  logic [NW*DW-1:0]  data_in = '0;
  logic [NR-1:0]     data_rden = '0;
  logic [NR*AW-1:0]  addr_rd = '0;
  logic [NR*DW-1:0]  data_out;
  logic [NR-1:0]     data_valid;
  logic [AW:0]       fill_count;
  logic              RAM_full;
  logic              wr_collision;

  ram_mrmw #(
    .DATA_SIZE(DW), .RAM_DEPTH_LOG2(AW), .NUM_WR(NW), .NUM_RD(NR), .BYPASS(BYP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .data_wren(data_wren), .addr_wr(addr_wr), .data_in(data_in),
    .data_rden(data_rden), .addr_rd(addr_rd),
    .data_out(data_out), .data_valid(data_valid),
    .fill_count(fill_count), .RAM_full(RAM_full), .wr_collision(wr_collision)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [DEPTH];
  bit            wr_m  [DEPTH];
  int            fill_m = 0;
  logic [DW-1:0] out_m [NR];
  logic [NR-1:0] valid_m = '0;
  bit            coll_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int a);
    if (BYP == 1 && !clear) begin
      for (int i = 0; i < NW; i++) begin
        if (data_wren[i] && int'(addr_wr[i*AW +: AW]) == a) return data_in[i*DW +: DW];
      end
    end
    return wr_m[a] ? mem_m[a] : '0;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) wr_m[a] = 1'b0;
    for (int j = 0; j < NR; j++) out_m[j] = '0;
    valid_m = '0;
    fill_m  = 0;
    coll_m  = 1'b0;
  endtask

  task automatic model_edge();
    bit claimed [DEPTH];
    int a;
    for (int j = 0; j < NR; j++) begin
      valid_m[j] = data_rden[j];
      if (data_rden[j]) out_m[j] = model_read(int'(addr_rd[j*AW +: AW]));
    end
    coll_m = 1'b0;
    if (clear) begin
      for (int e = 0; e < DEPTH; e++) wr_m[e] = 1'b0;
      fill_m = 0;
    end else begin
      for (int e = 0; e < DEPTH; e++) claimed[e] = 1'b0;
      for (int i = 0; i < NW; i++) begin
        if (data_wren[i]) begin
          a = int'(addr_wr[i*AW +: AW]);
          if (claimed[a]) begin
            coll_m = 1'b1;
          end else begin
            claimed[a] = 1'b1;
            mem_m[a] = data_in[i*DW +: DW];
            if (!wr_m[a]) begin
              wr_m[a] = 1'b1;
              fill_m++;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < NR; j++) begin
      check($sformatf("%s_out%0d", tag, j), 32'(data_out[j*DW +: DW]), 32'(out_m[j]));
    end
    check({tag, "_valid"}, 32'(data_valid), 32'(valid_m));
    check({tag, "_fill"}, 32'(fill_count), 32'(fill_m));
    check({tag, "_full"}, 32'(RAM_full), 32'(fill_m == DEPTH));
    check({tag, "_coll"}, 32'(wr_collision), 32'(coll_m));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    clear     = 1'b0;
    data_wren = '0;
    data_rden = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    data_wren[p] = 1'b1;
    addr_wr[p*AW +: AW] = AW'(a);
    data_in[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    data_rden[p] = 1'b1;
    addr_rd[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;

    // Two ports write different addresses, then cross-read.
    idle(); wr(0, 0, 16'habcd); wr(1, 1, 16'hef01);
    step("t1_wr");
    idle(); rd(0, 1); rd(1, 0);
    step("t1_rd");
    check("t1_lit_out0", 32'(data_out[15:0]), 32'h0000ef01);
    check("t1_lit_out1", 32'(data_out[31:16]), 32'h0000abcd);
    check("t1_lit_fill", 32'(fill_count), 32'd2);

    // Collision: port 0 wins, count grows by one, pulse lasts one cycle.
    idle(); wr(0, 5, 16'h1111); wr(1, 5, 16'h2222);
    step("t2_wr");
    check("t2_lit_coll", 32'(wr_collision), 32'd1);
    check("t2_lit_fill", 32'(fill_count), 32'd3);
    idle(); rd(0, 5);
    step("t2_rd");
    check("t2_lit_coll_gone", 32'(wr_collision), 32'd0);
    check("t2_lit_data", 32'(data_out[15:0]), 32'h00001111);

    // Read-during-write on the same address.
    idle(); wr(0, 7, 16'h0007);
    step("t3_pre");
    idle(); wr(1, 7, 16'h7777); rd(0, 7);
    step("t3_rdw");
    check("t3_lit_rdw", 32'(data_out[15:0]), (BYP == 1) ? 32'h00007777 : 32'h00000007);

    // Fill every entry, then rewrite one.
    for (int c = 0; c < DEPTH / 2; c++) begin
      idle(); wr(0, 2*c, DW'(16'h3000 + c)); wr(1, 2*c + 1, DW'(16'h4000 + c));
      step("t4_fill");
    end
    check("t4_lit_fill", 32'(fill_count), 32'd32);
    check("t4_lit_full", 32'(RAM_full), 32'd1);
    idle(); wr(0, 3, 16'h0303);
    step("t4_rewrite");
    check("t4_lit_refill", 32'(fill_count), 32'd32);

    // Clear beats simultaneous (colliding) writes.
    idle(); clear = 1'b1; wr(0, 9, 16'h9999); wr(1, 9, 16'h8888);
    step("t5_clr");
    check("t5_lit_fill", 32'(fill_count), 32'd0);
    check("t5_lit_full", 32'(RAM_full), 32'd0);
    check("t5_lit_coll", 32'(wr_collision), 32'd0);
    idle(); rd(1, 9);
    step("t5_rd");
    check("t5_lit_data", 32'(data_out[31:16]), 32'd0);

    // Randomized traffic with a narrow address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      clear = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          wr(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 3),
             DW'($urandom));
        end
      end
      for (int j = 0; j < NR; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          rd(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 3));
        end
      end
      step("rand");
    end

    // Asynchronous reset while read results are on the outputs.
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      if (!wr_m[a]) begin
        wr(0, a, 16'h5a5a);
        break;
      end
    end
    step("t6_prep");
    idle(); rd(0, 0); rd(1, 9);
    step("t6_rd");
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    check("t6_lit_valid", 32'(data_valid), 32'd0);
    check("t6_lit_out", 32'(data_out), 32'd0);
    #1;
    reset_n = 1'b1;
    for (int a = 0; a < DEPTH; a += 2) begin
      idle(); rd(0, a); rd(1, a + 1);
      step("t6_post");
      check("t6_lit_post", 32'(data_out), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
